// File: rtl/one_hot_mon_pkg.sv
`default_nettype none
// ============================================================================
// one_hot_mon_pkg : mode encodings and run-counter width helper
// Revision 1.0
// ============================================================================
package one_hot_mon_pkg;

   localparam logic [1:0] MODE_STRICT   = 2'd0;
   localparam logic [1:0] MODE_ZERO_OK  = 2'd1;
   localparam logic [1:0] MODE_ONE_COLD = 2'd2;

   function automatic int run_w(input int thresh);
      return $clog2(thresh + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/one_hot_monitor_if.sv
`default_nettype none
// ============================================================================
// one_hot_monitor_if : sample/control inputs and status outputs of the monitor
// Revision 1.0  (hot_idx present when ONE_HOT_MON_INDEX_EN is defined)
// ============================================================================
interface one_hot_monitor_if #(
   parameter int N     = 8,
   parameter int CNT_W = 8
);
   logic             en;
   logic             clr;
   logic [1:0]       mode;
   logic [N-1:0]     sig_in;
   logic             one_hot;
   logic             zero_det;
   logic             multi_det;
   logic             err_sticky;
   logic [CNT_W-1:0] err_cnt;
   logic             alarm;
`ifdef ONE_HOT_MON_INDEX_EN
   logic [$clog2(N)-1:0] hot_idx;
`endif

   modport master (
      output en, clr, mode, sig_in,
      input  one_hot, zero_det, multi_det, err_sticky, err_cnt, alarm
`ifdef ONE_HOT_MON_INDEX_EN
      , input hot_idx
`endif
   );

   modport slave (
      input  en, clr, mode, sig_in,
      output one_hot, zero_det, multi_det, err_sticky, err_cnt, alarm
`ifdef ONE_HOT_MON_INDEX_EN
      , output hot_idx
`endif
   );
endinterface
`default_nettype wire

// File: rtl/one_hot_classify.sv
`default_nettype none
// ============================================================================
// one_hot_classify : combinational zero / one / multi classification by bit fold
// Revision 1.0  (index output when ONE_HOT_MON_INDEX_EN is defined)
// ============================================================================
module one_hot_classify #(
   parameter int N = 8
) (
   input  wire logic [N-1:0] i_v,
`ifdef ONE_HOT_MON_INDEX_EN
   output logic [$clog2(N)-1:0] o_idx,
`endif
   output logic              o_is_zero,
   output logic              o_is_one,
   output logic              o_is_multi
);
   localparam int IDX_W = $clog2(N);

   logic             w_seen;
   logic             w_multi;
   logic [IDX_W-1:0] w_idx;

   // OR-folding indices is only meaningful when exactly one bit is set
   always_comb begin
      w_seen  = 1'b0;
      w_multi = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N; i++) begin
         w_multi = w_multi | (w_seen & i_v[i]);
         w_seen  = w_seen | i_v[i];
         w_idx   = w_idx | (i_v[i] ? IDX_W'(i) : '0);
      end
   end

   assign o_is_zero  = ~w_seen;
   assign o_is_one   = w_seen & ~w_multi;
   assign o_is_multi = w_multi;

`ifdef ONE_HOT_MON_INDEX_EN
   assign o_idx = w_idx;
`else
   logic w_unused_idx;
   assign w_unused_idx = ^w_idx;
`endif
endmodule
`default_nettype wire

// File: rtl/one_hot_monitor.sv
`default_nettype none
// ============================================================================
// one_hot_monitor : registered one-hot legality monitor with sticky error,
//                   saturating violation counter and consecutive-run alarm
// Revision 1.0  (optional hot_idx via ONE_HOT_MON_INDEX_EN)
// ============================================================================
module one_hot_monitor
   import one_hot_mon_pkg::*;
#(
   parameter int N      = 8,
   parameter int CNT_W  = 8,
   parameter int THRESH = 3
) (
   input wire logic      clk,
   input wire logic      rst_n,
   one_hot_monitor_if.slave bus
);
   localparam int RUN_W = run_w(THRESH);
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     w_v;
   logic             w_is_zero;
   logic             w_is_one;
   logic             w_is_multi;
   logic [IDX_W-1:0] w_idx;
   logic             w_legal;
   logic             w_viol;
   logic [RUN_W-1:0] w_run_next;

   logic             r_one_hot;
   logic             r_zero_det;
   logic             r_multi_det;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_alarm;
   logic [RUN_W-1:0] r_run;
   logic [IDX_W-1:0] r_hot_idx;

   assign w_v = (bus.mode == MODE_ONE_COLD) ? ~bus.sig_in : bus.sig_in;

   one_hot_classify #(.N(N)) u_classify (
      .i_v        (w_v),
`ifdef ONE_HOT_MON_INDEX_EN
      .o_idx      (w_idx),
`endif
      .o_is_zero  (w_is_zero),
      .o_is_one   (w_is_one),
      .o_is_multi (w_is_multi)
   );

`ifndef ONE_HOT_MON_INDEX_EN
   assign w_idx = '0;
`endif

   assign w_legal = (bus.mode == MODE_ZERO_OK) ? (w_is_zero | w_is_one) : w_is_one;
   assign w_viol  = bus.en & ~w_legal;

   // clr dominates a coincident violation; idle cycles hold the run
   always_comb begin
      w_run_next = r_run;
      if (bus.clr)
         w_run_next = '0;
      else if (w_viol)
         w_run_next = (r_run >= RUN_W'(THRESH)) ? r_run : r_run + 1'b1;
      else if (bus.en)
         w_run_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_one_hot    <= 1'b0;
         r_zero_det   <= 1'b0;
         r_multi_det  <= 1'b0;
         r_hot_idx    <= '0;
         r_err_sticky <= 1'b0;
         r_err_cnt    <= '0;
         r_run        <= '0;
         r_alarm      <= 1'b0;
      end else begin
         r_one_hot   <= bus.en & w_legal;
         r_zero_det  <= bus.en & w_is_zero;
         r_multi_det <= bus.en & w_is_multi;
         r_hot_idx   <= (bus.en & w_is_one & w_legal) ? w_idx : '0;
         r_run       <= w_run_next;
         r_alarm     <= (w_run_next >= RUN_W'(THRESH));
         if (bus.clr) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
         end else if (w_viol) begin
            r_err_sticky <= 1'b1;
            r_err_cnt    <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
         end
      end
   end

   assign bus.one_hot    = r_one_hot;
   assign bus.zero_det   = r_zero_det;
   assign bus.multi_det  = r_multi_det;
   assign bus.err_sticky = r_err_sticky;
   assign bus.err_cnt    = r_err_cnt;
   assign bus.alarm      = r_alarm;
`ifdef ONE_HOT_MON_INDEX_EN
   assign bus.hot_idx    = r_hot_idx;
`else
   logic w_unused_idx;
   assign w_unused_idx = ^r_hot_idx;
`endif
endmodule
`default_nettype wire
